// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data-memory port between the CPU load/store path and a
//   host loader/debug port. The CPU has priority. A CPU load takes two cycles:
//   the issue cycle stalls the CPU, and the data returns registered in the
//   following LD_DONE cycle. A starvation counter forces a host slot after
//   STARVE_LIM consecutive denied host cycles. The forced slot stalls the CPU.
//
// Ports
//   Clk, Rst                 clock, asynchronous active-high reset
//   Cpu_Req/We/Addr/WData    CPU access request, held until Cpu_Stall is low
//   Cpu_Stall                CPU must hold PC and inputs this cycle
//   Cpu_RData/Cpu_RValid     registered load data, 1-cycle valid pulse
//   Host_Req/We/Addr/WData   host access request, stable while Host_Req is high
//   Host_Gnt                 host access performed this cycle
//   Host_RData/Host_RValid   registered read data, valid the cycle after Gnt
//   Mem_Addr/WData/We        to DataMemoryUnit
//   Mem_RData                from DataMemoryUnit (combinational read)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cpu_Req,
  input  logic              Cpu_We,
  input  logic [ADDR_W-1:0] Cpu_Addr,
  input  logic [DATA_W-1:0] Cpu_WData,
  output logic              Cpu_Stall,
  output logic [DATA_W-1:0] Cpu_RData,
  output logic              Cpu_RValid,
  input  logic              Host_Req,
  input  logic              Host_We,
  input  logic [ADDR_W-1:0] Host_Addr,
  input  logic [DATA_W-1:0] Host_WData,
  output logic              Host_Gnt,
  output logic [DATA_W-1:0] Host_RData,
  output logic              Host_RValid,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  output logic              Mem_We,
  input  logic [DATA_W-1:0] Mem_RData
);

  localparam int                 CNT_W   = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STARVE_LIM);

  typedef enum logic {
    IDLE    = 1'b0,  // no CPU load in flight
    LD_DONE = 1'b1   // CPU load data returned this cycle; memory port free
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                host_rvalid_q, host_rvalid_d;

  logic cpu_cand, force_host, host_gnt, cpu_gnt, cpu_load_gnt, host_read_gnt;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    cpu_cand      = 1'b0;
    force_host    = 1'b0;
    host_gnt      = 1'b0;
    cpu_gnt       = 1'b0;
    cpu_load_gnt  = 1'b0;
    host_read_gnt = 1'b0;
    Mem_Addr      = '0;
    Mem_WData     = '0;
    Mem_We        = 1'b0;
    Cpu_Stall     = 1'b0;
    state_d       = IDLE;
    starve_d      = '0;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_rvalid_d  = 1'b0;
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = 1'b0;

    // In LD_DONE the CPU's held request is the load that just completed, so
    // it is not a candidate and the port is free for the host.
    cpu_cand   = Cpu_Req & (state_q == IDLE);
    force_host = Host_Req & (starve_q == CNT_MAX);
    host_gnt   = Host_Req & (force_host | ~cpu_cand);
    cpu_gnt    = cpu_cand & ~host_gnt;

    if (host_gnt) begin
      Mem_Addr  = Host_Addr;
      Mem_WData = Host_WData;
      Mem_We    = Host_We;
    end else if (cpu_gnt) begin
      Mem_Addr  = Cpu_Addr;
      Mem_WData = Cpu_WData;
      Mem_We    = Cpu_We;
    end

    // Stall when arbitration is lost, and always on a load's issue cycle.
    Cpu_Stall = cpu_cand & (~cpu_gnt | ~Cpu_We);

    cpu_load_gnt  = cpu_gnt & ~Cpu_We;
    host_read_gnt = host_gnt & ~Host_We;

    if (cpu_load_gnt) begin
      state_d     = LD_DONE;
      cpu_rdata_d = Mem_RData;
    end
    cpu_rvalid_d = cpu_load_gnt;

    if (host_read_gnt) begin
      host_rdata_d = Mem_RData;
    end
    host_rvalid_d = host_read_gnt;

    // Count consecutive denied host cycles; any grant or idle host clears it.
    if (Host_Req & ~host_gnt) begin
      starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      cpu_rdata_q   <= '0;
      cpu_rvalid_q  <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign Host_Gnt    = host_gnt;
  assign Cpu_RData   = cpu_rdata_q;
  assign Cpu_RValid  = cpu_rvalid_q;
  assign Host_RData  = host_rdata_q;
  assign Host_RValid = host_rvalid_q;

endmodule
